// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types, forward selects and decode constants
package pipe_pkg;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Opcode/funct values shared with the control unit
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;

  // A source matches a producer only if it is a real register being written
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst, input logic wr);
    return (src != 5'd0) && wr && (src == dst);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - combinational operand forwarding selects for E and D stages
module fwd_unit
  import pipe_pkg::*;
(
  input  logic       en_i,
  input  logic [4:0] rs_d_i,
  input  logic [4:0] rt_d_i,
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rt_e_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] write_reg_m_i,
  input  logic       reg_write_w_i,
  input  logic [4:0] write_reg_w_i,
  output logic [1:0] fwd_a_e_o,
  output logic [1:0] fwd_b_e_o,
  output logic       fwd_a_d_o,
  output logic       fwd_b_d_o
);

  function automatic logic [1:0] sel_e(input logic [4:0] src);
    if (reg_hit(src, write_reg_m_i, reg_write_m_i)) return FWD_M;
    if (reg_hit(src, write_reg_w_i, reg_write_w_i)) return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_e_o = FWD_RF;
    fwd_b_e_o = FWD_RF;
    fwd_a_d_o = 1'b0;
    fwd_b_d_o = 1'b0;
    if (en_i) begin
      fwd_a_e_o = sel_e(rs_e_i);
      fwd_b_e_o = sel_e(rt_e_i);
      fwd_a_d_o = reg_hit(rs_d_i, write_reg_m_i, reg_write_m_i);
      fwd_b_d_o = reg_hit(rt_d_i, write_reg_m_i, reg_write_m_i);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencer: fill counter, stalls, flushes, memory-wait freeze
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FILL_CYCLES = 2,
  parameter int unsigned WAIT_MAX    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic [4:0] WriteRegE,
  input  logic       RegWriteM,
  input  logic       MemtoRegM,
  input  logic [4:0] WriteRegM,
  input  logic       MemWriteM,
  input  logic       RegWriteW,
  input  logic [4:0] WriteRegW,
  input  logic       mem_ready,
  output logic [3:0] cnt,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       mem_timeout
);

  localparam logic [3:0] FILL_LAST = 4'(FILL_CYCLES - 1);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  pipe_state_e state_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q;

  logic mem_miss;
  logic lwstall;
  logic branchstall;
  logic hazard;
  logic fwd_en;

  assign mem_miss    = (MemtoRegM | MemWriteM) & ~mem_ready;
  assign lwstall     = MemtoRegE & ((RtE == RsD) | (RtE == RtD));
  assign branchstall = BranchD & ((RegWriteE & ((WriteRegE == RsD) | (WriteRegE == RtD)))
                                | (MemtoRegM & ((WriteRegM == RsD) | (WriteRegM == RtD))));
  assign hazard      = lwstall | branchstall;

  assign cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == RUN && mem_miss) begin
      wait_cnt_d = 4'd0;
    end else if (state_q == MEM_WAIT && wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FILL;
      cnt_q         <= 4'd0;
      wait_cnt_q    <= 4'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
      unique case (state_q)
        FILL: begin
          if (cnt_q == FILL_LAST) state_q <= RUN;
        end
        RUN: begin
          if (mem_miss) state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q <= RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q       <= RUN;
            mem_timeout_q <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // A memory miss freezes the whole pipe in the very cycle it is seen
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    fwd_en = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      unique case (state_q)
        FILL: begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end
        RUN: begin
          fwd_en = 1'b1;
          if (mem_miss) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
          end else begin
            StallF = hazard;
            StallD = hazard;
            FlushE = hazard;
            FlushD = PCSrcD & ~hazard;
          end
        end
        MEM_WAIT: begin
          fwd_en = 1'b1;
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
        end
        default: begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end
      endcase
    end
  end

  fwd_unit u_fwd (
    .en_i          (fwd_en),
    .rs_d_i        (RsD),
    .rt_d_i        (RtD),
    .rs_e_i        (RsE),
    .rt_e_i        (RtE),
    .reg_write_m_i (RegWriteM),
    .write_reg_m_i (WriteRegM),
    .reg_write_w_i (RegWriteW),
    .write_reg_w_i (WriteRegW),
    .fwd_a_e_o     (ForwardAE),
    .fwd_b_e_o     (ForwardBE),
    .fwd_a_d_o     (ForwardAD),
    .fwd_b_d_o     (ForwardBD)
  );

  assign cnt         = cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int FILL_CYCLES = 2;
  localparam int WAIT_MAX    = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       BranchD, PCSrcD, RegWriteE, MemtoRegE;
  logic       RegWriteM, MemtoRegM, MemWriteM, RegWriteW, mem_ready;
  logic [3:0] cnt;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, mem_timeout;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: cycles since reset, whether a memory access is outstanding
  int age, waited;
  bit in_wait, m_to;

  always #5 clk = ~clk;

  hazard_ctrl #(.FILL_CYCLES(FILL_CYCLES), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .BranchD(BranchD), .PCSrcD(PCSrcD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .mem_ready(mem_ready),
    .cnt(cnt), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .mem_timeout(mem_timeout)
  );

  function automatic bit miss_now();
    return (MemtoRegM || MemWriteM) && !mem_ready;
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] r);
    if (r != 0 && RegWriteM && r == WriteRegM) return 2'd2;
    if (r != 0 && RegWriteW && r == WriteRegW) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [16:0] expect_out();
    logic [1:0] fae, fbe;
    logic fad, fbd, sf, sd, se, sm, fd, fe;
    bit lw, br, hz;
    int c;
    c = (age > 15) ? 15 : age;
    {fae, fbe, fad, fbd, sf, sd, se, sm, fd, fe} = '0;
    if (!rst_n || age < FILL_CYCLES) begin
      fd = 1'b1;
      fe = 1'b1;
    end else begin
      fae = fsel(RsE);
      fbe = fsel(RtE);
      fad = (RsD != 0) && RegWriteM && (RsD == WriteRegM);
      fbd = (RtD != 0) && RegWriteM && (RtD == WriteRegM);
      if (in_wait || miss_now()) begin
        {sf, sd, se, sm} = 4'hF;
      end else begin
        lw = MemtoRegE && (RtE == RsD || RtE == RtD);
        br = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                         (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
        hz = lw || br;
        sf = hz;
        sd = hz;
        fe = hz;
        fd = PCSrcD && !hz;
      end
    end
    return {4'(c), sf, sd, se, sm, fd, fe, fae, fbe, fad, fbd, m_to};
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      age = 0; in_wait = 0; waited = 0; m_to = 0;
    end else begin
      if (age >= FILL_CYCLES) begin
        if (in_wait) begin
          if (mem_ready) in_wait = 0;
          else if (waited == WAIT_MAX - 1) begin
            in_wait = 0;
            m_to = 1;
          end else waited++;
        end else if (miss_now()) begin
          in_wait = 1;
          waited = 0;
        end
      end
      if (age < 1000) age++;
    end
  endtask

  // Move to the falling edge and compare every output against the model
  task automatic look();
    logic [16:0] act, exp;
    #4;
    act = {cnt, StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, mem_timeout};
    exp = expect_out();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cycle_outputs t=%0t got=%05h want=%05h", $time, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic clear_in();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {BranchD, PCSrcD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, MemWriteM, RegWriteW} = '0;
    mem_ready = 1'b1;
  endtask

  task automatic rand_in();
    RsD = 5'($urandom_range(0, 3));
    RtD = 5'($urandom_range(0, 3));
    RsE = 5'($urandom_range(0, 3));
    RtE = 5'($urandom_range(0, 3));
    WriteRegE = 5'($urandom_range(0, 3));
    WriteRegM = 5'($urandom_range(0, 3));
    WriteRegW = 5'($urandom_range(0, 3));
    BranchD   = 1'($urandom_range(0, 1));
    PCSrcD    = 1'($urandom_range(0, 1));
    RegWriteE = 1'($urandom_range(0, 1));
    MemtoRegE = 1'($urandom_range(0, 3) == 0);
    RegWriteM = 1'($urandom_range(0, 1));
    MemtoRegM = 1'($urandom_range(0, 3) == 0);
    MemWriteM = 1'($urandom_range(0, 5) == 0);
    RegWriteW = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int low_run;
    clear_in();
    rst_n = 1'b0;
    age = 0; waited = 0; in_wait = 0; m_to = 0;
    adv();
    look(); adv();
    rst_n = 1'b1;

    // Fill counter and start-up flush
    for (int k = 0; k < 18; k++) begin
      look();
      lit("fill_cnt", int'(cnt), (k > 15) ? 15 : k);
      lit("fill_flushE", int'(FlushE), (k < 2) ? 1 : 0);
      adv();
    end

    // Forwarding priority and $0 exclusion
    RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; RsE = 8;
    look(); lit("fwd_m_prio", int'(ForwardAE), 2); adv();
    RsE = 0;
    look(); lit("fwd_r0", int'(ForwardAE), 0); adv();

    // Load-use stall, then forward from M
    clear_in();
    MemtoRegE = 1; RtE = 9; RsD = 9;
    look();
    lit("lw_stallF", int'(StallF), 1);
    lit("lw_stallD", int'(StallD), 1);
    lit("lw_flushE", int'(FlushE), 1);
    adv();
    clear_in();
    MemtoRegM = 1; RegWriteM = 1; WriteRegM = 9; RsE = 9;
    look();
    lit("lw_next_stallF", int'(StallF), 0);
    lit("lw_next_fwdA", int'(ForwardAE), 2);
    adv();

    // Branch stall beats taken-branch flush
    clear_in();
    BranchD = 1; RsD = 5; RegWriteE = 1; WriteRegE = 5; PCSrcD = 1;
    look();
    lit("br_stallD", int'(StallD), 1);
    lit("br_flushD", int'(FlushD), 0);
    adv();
    clear_in();
    PCSrcD = 1;
    look(); lit("taken_flushD", int'(FlushD), 1); adv();

    // Memory wait freeze
    clear_in();
    MemtoRegM = 1; mem_ready = 0;
    look(); lit("mw_c1_stallM", int'(StallM), 1); adv();
    look(); lit("mw_c2_stallE", int'(StallE), 1); adv();
    mem_ready = 1;
    look(); lit("mw_c3_stallF", int'(StallF), 1); adv();
    MemtoRegM = 0;
    look();
    lit("mw_run_stallF", int'(StallF), 0);
    lit("mw_run_timeout", int'(mem_timeout), 0);
    adv();

    // Timeout after WAIT_MAX wait cycles, sticky
    MemtoRegM = 1; mem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      look(); lit("to_pending", int'(mem_timeout), 0); adv();
    end
    look(); lit("to_set", int'(mem_timeout), 1); adv();
    look(); lit("to_sticky", int'(mem_timeout), 1); lit("to_wait_stallM", int'(StallM), 1); adv();

    // Reset in the middle of a memory wait
    rst_n = 0;
    look(); lit("rst_stallF", int'(StallF), 0); lit("rst_flushE", int'(FlushE), 1); adv();
    rst_n = 1;
    look();
    lit("rst_cnt", int'(cnt), 0);
    lit("rst_timeout", int'(mem_timeout), 0);
    lit("rst_stallM", int'(StallM), 0);
    adv();

    // Random traffic with long not-ready bursts and occasional resets
    low_run = 0;
    for (int n = 0; n < 3000; n++) begin
      rand_in();
      if (low_run == 0 && $urandom_range(0, 60) == 0) low_run = $urandom_range(5, 24);
      if (low_run > 0) begin
        mem_ready = 1'b0;
        MemtoRegM = 1'b1;
        low_run--;
      end else begin
        mem_ready = 1'($urandom_range(0, 2) != 0);
      end
      rst_n = ($urandom_range(0, 250) == 0) ? 1'b0 : 1'b1;
      look();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
